// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the EX-stage iterative divider.
// Holds the operand width, divider state encoding and divide-by-zero quotient values.
package cpu_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Quotient returned for x/0: all ones unless a signed dividend is negative.
  localparam logic signed [DIV_WIDTH-1:0] DIVZ_Q_POS = '1;
  localparam logic        [DIV_WIDTH-1:0] DIVZ_Q_NEG = DIV_WIDTH'(1);

endpackage

// File: rtl/iter_divider_if.sv
// Divide request/response bundle: two independent operand valid/ready channels
// plus a result that is only a valid pulse (no ready, the consumer must sample it).
interface iter_divider_if
  import cpu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
);

  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tvalid;

  modport master (
    output s_axis_dividend_tdata,
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_divisor_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tvalid
  );

  modport slave (
    input  s_axis_dividend_tdata,
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_divisor_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    output m_axis_dout_tdata,
    output m_axis_dout_tvalid
  );

endinterface

// File: rtl/div_abs_sign.sv
// Combinational magnitude/sign helper: in abs_mode it strips the operand sign,
// otherwise it negates din when neg_in is set (used to re-sign the results).
module div_abs_sign #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic [WIDTH-1:0] din,
  input  logic             abs_mode,
  input  logic             neg_in,
  output logic             sgn,
  output logic [WIDTH-1:0] dout
);

  logic neg;

  always_comb begin
    sgn  = SIGNED ? din[WIDTH-1] : 1'b0;
    neg  = abs_mode ? sgn : neg_in;
    dout = neg ? (~din + WIDTH'(1)) : din;
  end

endmodule

// File: rtl/iter_divider.sv
// Restoring shift-subtract divider, one quotient bit per cycle; result pulses WIDTH+1
// cycles after the second operand is taken. Both operand readys stay low until the op retires.
module iter_divider
  import cpu_pkg::*;
#(
  parameter int WIDTH  = DIV_WIDTH,
  parameter bit SIGNED = 1'b1
) (
  input  logic          clk,
  input  logic          resetn,
  iter_divider_if.slave div_bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t state;

  logic             dvd_full, dvs_full;
  logic [WIDTH-1:0] dvd_hold, dvs_hold;
  logic             dvd_rdy, dvs_rdy, dvd_acc, dvs_acc, start;
  logic [WIDTH-1:0] dvd_cur, dvs_cur;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             a_sgn, b_sgn;

  logic [WIDTH-1:0] a_sh, b_reg, q, rem;
  logic [CW-1:0]    cnt;
  logic             qneg, rneg, divz;

  logic [WIDTH:0]   rem_sh;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nxt;

  logic [WIDTH-1:0] q_res, r_res, q_out;
  logic             q_sgn_unused, r_sgn_unused;

  logic [2*WIDTH-1:0] dout_tdata;
  logic               dout_tvalid;

  assign dvd_rdy = !dvd_full && (state == IDLE);
  assign dvs_rdy = !dvs_full && (state == IDLE);
  assign dvd_acc = div_bus.s_axis_dividend_tvalid && dvd_rdy;
  assign dvs_acc = div_bus.s_axis_divisor_tvalid && dvs_rdy;

  // Start on the edge where the last missing operand lands (or both land together).
  assign start = (state == IDLE) && (dvd_acc || dvs_acc) &&
                 (dvd_full || dvd_acc) && (dvs_full || dvs_acc);

  assign dvd_cur = dvd_acc ? div_bus.s_axis_dividend_tdata : dvd_hold;
  assign dvs_cur = dvs_acc ? div_bus.s_axis_divisor_tdata  : dvs_hold;

  div_abs_sign #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_abs_a (
    .din      (dvd_cur),
    .abs_mode (1'b1),
    .neg_in   (1'b0),
    .sgn      (a_sgn),
    .dout     (a_mag)
  );

  div_abs_sign #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_abs_b (
    .din      (dvs_cur),
    .abs_mode (1'b1),
    .neg_in   (1'b0),
    .sgn      (b_sgn),
    .dout     (b_mag)
  );

  // The partial remainder stays below |b|, so the W-bit difference is exact.
  assign rem_sh  = {rem, a_sh[WIDTH-1]};
  assign q_bit   = (rem_sh >= {1'b0, b_reg});
  assign rem_nxt = q_bit ? (rem_sh[WIDTH-1:0] - b_reg) : rem_sh[WIDTH-1:0];

  div_abs_sign #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_neg_q (
    .din      (q),
    .abs_mode (1'b0),
    .neg_in   (qneg),
    .sgn      (q_sgn_unused),
    .dout     (q_res)
  );

  div_abs_sign #(.WIDTH(WIDTH), .SIGNED(SIGNED)) u_neg_r (
    .din      (rem),
    .abs_mode (1'b0),
    .neg_in   (rneg),
    .sgn      (r_sgn_unused),
    .dout     (r_res)
  );

  assign q_out = divz ? (rneg ? WIDTH'(DIVZ_Q_NEG) : WIDTH'(DIVZ_Q_POS)) : q_res;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dvd_full <= 1'b0;
      dvs_full <= 1'b0;
      dvd_hold <= '0;
      dvs_hold <= '0;
    end else if (state == DONE) begin
      dvd_full <= 1'b0;
      dvs_full <= 1'b0;
    end else begin
      if (dvd_acc) begin
        dvd_full <= 1'b1;
        dvd_hold <= div_bus.s_axis_dividend_tdata;
      end
      if (dvs_acc) begin
        dvs_full <= 1'b1;
        dvs_hold <= div_bus.s_axis_divisor_tdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      a_sh  <= '0;
      b_reg <= '0;
      q     <= '0;
      rem   <= '0;
      cnt   <= '0;
      qneg  <= 1'b0;
      rneg  <= 1'b0;
      divz  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= CALC;
            a_sh  <= a_mag;
            b_reg <= b_mag;
            q     <= '0;
            rem   <= '0;
            cnt   <= '0;
            qneg  <= a_sgn ^ b_sgn;
            rneg  <= a_sgn;
            divz  <= (b_mag == '0);
          end
        end
        CALC: begin
          a_sh <= a_sh << 1;
          rem  <= rem_nxt;
          q    <= {q[WIDTH-2:0], q_bit};
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Result register holds across ops; only a new DONE or reset changes it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_tdata  <= '0;
      dout_tvalid <= 1'b0;
    end else begin
      dout_tvalid <= (state == DONE);
      if (state == DONE) dout_tdata <= {q_out, r_res};
    end
  end

  assign div_bus.s_axis_dividend_tready = dvd_rdy;
  assign div_bus.s_axis_divisor_tready  = dvs_rdy;
  assign div_bus.m_axis_dout_tdata      = dout_tdata;
  assign div_bus.m_axis_dout_tvalid     = dout_tvalid;

endmodule

// File: tb/tb_iter_divider.sv
// Bench for an unsigned and a signed iter_divider: queued expectations are checked
// against each result pulse, its latency, its width and the held output value.
module tb_iter_divider;

  logic clk = 1'b0;
  logic resetn;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [63:0] d;
    logic [31:0] c;
  } exp_t;

  exp_t sb0[$];
  exp_t sb1[$];

  logic [31:0] dvd_dat[2];
  logic [31:0] dvs_dat[2];
  logic        dvd_vld[2];
  logic        dvs_vld[2];
  logic        dvd_rdy[2];
  logic        dvs_rdy[2];
  logic        out_vld[2];
  logic [63:0] out_dat[2];
  logic [63:0] last_d[2];
  logic        prev_v[2];

  iter_divider_if #(.WIDTH(32)) if_u ();
  iter_divider_if #(.WIDTH(32)) if_s ();

  assign if_u.s_axis_dividend_tdata  = dvd_dat[0];
  assign if_u.s_axis_dividend_tvalid = dvd_vld[0];
  assign if_u.s_axis_divisor_tdata   = dvs_dat[0];
  assign if_u.s_axis_divisor_tvalid  = dvs_vld[0];
  assign if_s.s_axis_dividend_tdata  = dvd_dat[1];
  assign if_s.s_axis_dividend_tvalid = dvd_vld[1];
  assign if_s.s_axis_divisor_tdata   = dvs_dat[1];
  assign if_s.s_axis_divisor_tvalid  = dvs_vld[1];

  assign dvd_rdy[0] = if_u.s_axis_dividend_tready;
  assign dvs_rdy[0] = if_u.s_axis_divisor_tready;
  assign out_vld[0] = if_u.m_axis_dout_tvalid;
  assign out_dat[0] = if_u.m_axis_dout_tdata;
  assign dvd_rdy[1] = if_s.s_axis_dividend_tready;
  assign dvs_rdy[1] = if_s.s_axis_divisor_tready;
  assign out_vld[1] = if_s.m_axis_dout_tvalid;
  assign out_dat[1] = if_s.m_axis_dout_tdata;

  iter_divider #(.WIDTH(32), .SIGNED(1'b0)) u_div_u (.clk(clk), .resetn(resetn), .div_bus(if_u));
  iter_divider #(.WIDTH(32), .SIGNED(1'b1)) u_div_s (.clk(clk), .resetn(resetn), .div_bus(if_s));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model(input bit sg, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sbv;
    sa  = a;
    sbv = b;
    if (b == 32'd0) return {(sg && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF, a};
    if (!sg) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    return {32'(sa / sbv), 32'(sa % sbv)};
  endfunction

  task automatic mon(input int s);
    exp_t e;
    int   n;
    n = (s == 0) ? sb0.size() : sb1.size();
    if (out_vld[s]) begin
      chk("pulse_width", 64'(prev_v[s]), 64'd0);
      chk("pulse_expected", 64'(n != 0), 64'd1);
      if (n != 0) begin
        if (s == 0) e = sb0.pop_front();
        else        e = sb1.pop_front();
        chk("dout", out_dat[s], e.d);
        chk("latency", 64'(cyc), 64'(e.c));
      end
      last_d[s] = out_dat[s];
    end else begin
      chk("dout_hold", out_dat[s], last_d[s]);
    end
    prev_v[s] = out_vld[s];
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        last_d[i] = 64'd0;
        prev_v[i] = 1'b0;
      end
    end else begin
      mon(0);
      mon(1);
    end
  end

  // Called at a negedge; returns at the negedge after both operands were taken.
  task automatic run_op(input int s, input logic [31:0] a, input logic [31:0] b, input int b_delay,
                        input logic [63:0] exp, input bit push, output int acc_edge);
    bit   a_done, b_done, acc_a, acc_b;
    exp_t e;
    a_done   = 1'b0;
    b_done   = 1'b0;
    acc_edge = 0;
    for (int t = 0; t < 300 && !(a_done && b_done); t++) begin
      dvd_dat[s] = a;
      dvs_dat[s] = b;
      dvd_vld[s] = !a_done;
      dvs_vld[s] = !b_done && (t >= b_delay);
      acc_a = dvd_vld[s] && dvd_rdy[s];
      acc_b = dvs_vld[s] && dvs_rdy[s];
      if (acc_a || acc_b) acc_edge = cyc + 1;
      @(negedge clk);
      a_done = a_done | acc_a;
      b_done = b_done | acc_b;
      if (a_done != b_done) begin
        chk("dvd_rdy_slot", 64'(dvd_rdy[s]), 64'(!a_done));
        chk("dvs_rdy_slot", 64'(dvs_rdy[s]), 64'(!b_done));
      end else if (a_done && (acc_a || acc_b)) begin
        chk("rdy_busy", 64'({dvd_rdy[s], dvs_rdy[s]}), 64'd0);
      end
    end
    dvd_vld[s] = 1'b0;
    dvs_vld[s] = 1'b0;
    if (!(a_done && b_done)) begin
      chk("accept_timeout", 64'({a_done, b_done}), 64'd3);
    end else if (push) begin
      e.d = exp;
      e.c = 32'(acc_edge + 33);
      if (s == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = (s == 0) ? sb0.size() : sb1.size();
    for (int i = 0; i < 120 && n != 0; i++) begin
      @(negedge clk);
      n = (s == 0) ? sb0.size() : sb1.size();
    end
    chk("idle_timeout", 64'(n), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          e1, e2;
    logic [31:0] ra, rb;
    resetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      dvd_dat[i] = '0;
      dvs_dat[i] = '0;
      dvd_vld[i] = 1'b0;
      dvs_vld[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_dvd_rdy", 64'(dvd_rdy[s]), 64'd1);
      chk("reset_dvs_rdy", 64'(dvs_rdy[s]), 64'd1);
      chk("reset_vld", 64'(out_vld[s]), 64'd0);
      chk("reset_dout", out_dat[s], 64'd0);
    end

    // Unsigned instance
    run_op(0, 32'd7, 32'd2, 0, 64'h0000_0003_0000_0001, 1'b1, e1);
    run_op(0, 32'h1234_5678, 32'd0, 0, 64'hFFFF_FFFF_1234_5678, 1'b1, e1);
    run_op(0, 32'hFFFF_FFFF, 32'd16, 0, 64'h0FFF_FFFF_0000_000F, 1'b1, e1);
    wait_idle(0);
    run_op(0, 32'd100, 32'd7, 4, 64'h0000_000E_0000_0002, 1'b1, e1);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'd3;
      run_op(0, ra, rb, $urandom_range(0, 3), model(1'b0, ra, rb), 1'b1, e1);
    end
    wait_idle(0);

    // Signed instance
    run_op(1, 32'hFFFF_FFF9, 32'd2, 0, 64'hFFFF_FFFD_FFFF_FFFF, 1'b1, e1);
    run_op(1, 32'd7, 32'hFFFF_FFFE, 0, 64'hFFFF_FFFD_0000_0001, 1'b1, e1);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 64'h8000_0000_0000_0000, 1'b1, e1);
    run_op(1, 32'hFFFF_FFFB, 32'd0, 0, 64'h0000_0001_FFFF_FFFB, 1'b1, e1);
    run_op(1, 32'd5, 32'd0, 0, 64'hFFFF_FFFF_0000_0005, 1'b1, e1);
    run_op(1, 32'd1000, 32'hFFFF_FFDF, 0, 64'hFFFF_FFE2_0000_000A, 1'b1, e1);
    run_op(1, 32'hFFFF_FC18, 32'd33, 0, 64'hFFFF_FFE2_FFFF_FFF6, 1'b1, e2);
    chk("b2b_gap", 64'(e2 - e1), 64'd34);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (rb == 32'd0) rb = 32'hFFFF_FFF0;
      run_op(1, ra, rb, $urandom_range(0, 3), model(1'b1, ra, rb), 1'b1, e1);
    end

    // Abort an op with an asynchronous reset at iteration 10
    run_op(1, 32'd12345, 32'd6, 0, 64'd0, 1'b0, e1);
    repeat (10) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    chk("abort_vld", 64'(out_vld[1]), 64'd0);
    chk("abort_dout", out_dat[1], 64'd0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_dvd_rdy", 64'(dvd_rdy[1]), 64'd1);
    chk("abort_dvs_rdy", 64'(dvs_rdy[1]), 64'd1);
    repeat (40) @(negedge clk);
    run_op(1, 32'd9, 32'd3, 0, 64'h0000_0003_0000_0000, 1'b1, e1);

    wait_idle(0);
    wait_idle(1);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
